// File: rtl/car_pkg.sv
// Shared constants, types and helper functions for the road-lane car controller.
package car_pkg;

    localparam int unsigned GRID_W_DEFAULT = 20;
    localparam int unsigned X_W_DEFAULT    = 5;

    // Jitter LFSR: taps 16,14,13,11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } lane_state_t;

    // Step period for a level, clamped at min_p; level 0 behaves like level 1.
    function automatic logic [31:0] period(input logic [31:0] level,
                                           input logic [31:0] base,
                                           input logic [31:0] step,
                                           input logic [31:0] min_p);
        logic [31:0] leff;
        logic [31:0] dec;
        logic [31:0] p;
        leff = (level == 32'd0) ? 32'd1 : level;
        dec  = (leff - 32'd1) * step;
        if (dec >= base) begin
            p = min_p;
        end else begin
            p = base - dec;
            if (p < min_p) p = min_p;
        end
        return p;
    endfunction

    function automatic int unsigned spawn_x(input int unsigned k,
                                            input int unsigned init,
                                            input int unsigned grid,
                                            input int unsigned n);
        return (init + k * (grid / n)) % grid;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/car_step_timer.sv
// Level-dependent step timer: reloadable down-counter producing a one-cycle step request.
// Optional period jitter from a 16-bit LFSR when CAR_LANE_JITTER_EN is defined.
module car_step_timer
    import car_pkg::*;
#(
    parameter int unsigned LEVEL_W     = 7,
    parameter logic [23:0] BASE_PERIOD = 24'd6000000,
    parameter logic [23:0] PERIOD_STEP = 24'd300000,
    parameter logic [23:0] MIN_PERIOD  = 24'd750000
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_enable,
    input  logic               i_restart,
    input  logic [LEVEL_W-1:0] i_level,
    output logic               o_step_req
);

    localparam logic [31:0] PERIOD_L1  = period(32'd1, 32'(BASE_PERIOD),
                                                32'(PERIOD_STEP), 32'(MIN_PERIOD));
    localparam logic [31:0] RESET_LOAD = (PERIOD_L1 <= 32'd1) ? 32'd0 : PERIOD_L1 - 32'd1;

    lane_state_t state_q;
    lane_state_t state_d;
    logic        count_en;
    logic [31:0] count_q;
    logic [31:0] period_raw;
    logic [31:0] period_eff;
    logic [31:0] jitter;
    logic [31:0] reload_val;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        case (state_q)
            ST_RUN:  if (!i_enable) state_d = ST_HOLD;
            ST_HOLD: if (i_enable)  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        count_en = i_enable;
    end

`ifdef CAR_LANE_JITTER_EN
    logic [15:0] lfsr_q;

    // Not reseeded by restart, so only a full reset replays the jitter sequence.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)         lfsr_q <= LFSR_SEED;
        else if (o_step_req) lfsr_q <= lfsr_next(lfsr_q);
    end

    assign jitter = {30'd0, lfsr_q[1:0]};
`else
    assign jitter = 32'd0;
`endif

    always_comb begin
        period_raw = period(32'(i_level), 32'(BASE_PERIOD), 32'(PERIOD_STEP), 32'(MIN_PERIOD));
        period_eff = (period_raw <= 32'd1) ? 32'd1 : period_raw;
        reload_val = period_eff + jitter - 32'd1;
    end

    assign o_step_req = count_en && (count_q == 32'd0) && !i_restart;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            count_q <= RESET_LOAD;
        end else if (i_restart) begin
            count_q <= reload_val;
        end else if (count_en) begin
            if (count_q == 32'd0) count_q <= reload_val;
            else                  count_q <= count_q - 32'd1;
        end
    end

endmodule

// File: rtl/car_lane_ctrl.sv
// Lane of evenly spaced wrapping cars with registered positions, occupancy bitmap and step pulse.
// Build option CAR_LANE_JITTER_EN adds LFSR jitter to the step period (see car_step_timer).
module car_lane_ctrl
    import car_pkg::*;
#(
    parameter int unsigned GRID_W      = GRID_W_DEFAULT,
    parameter int unsigned X_W         = X_W_DEFAULT,
    parameter int unsigned NUM_CARS    = 3,
    parameter int unsigned CAR_INIT_X  = 0,
    parameter bit          DIRECTION   = 1'b1,
    parameter int unsigned LEVEL_W     = 7,
    parameter logic [23:0] BASE_PERIOD = 24'd6000000,
    parameter logic [23:0] PERIOD_STEP = 24'd300000,
    parameter logic [23:0] MIN_PERIOD  = 24'd750000
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_enable,
    input  logic                      i_restart,
    input  logic [LEVEL_W-1:0]        i_level,
    output logic [NUM_CARS*X_W-1:0]   o_car_x,
    output logic [GRID_W-1:0]         o_occupied,
    output logic                      o_step
);

    if (GRID_W / NUM_CARS == 0) begin : g_bad_spacing
        $error("car_lane_ctrl: GRID_W/NUM_CARS must be at least 1");
    end
    if ((2 ** X_W) < GRID_W) begin : g_bad_width
        $error("car_lane_ctrl: X_W too narrow for GRID_W");
    end

    logic              step_req;
    logic [X_W-1:0]    spawn_c   [NUM_CARS];
    logic [X_W-1:0]    car_x_q   [NUM_CARS];
    logic [X_W-1:0]    car_x_d   [NUM_CARS];
    logic [GRID_W-1:0] spawn_occ;
    logic [GRID_W-1:0] occ_d;

    car_step_timer #(
        .LEVEL_W     (LEVEL_W),
        .BASE_PERIOD (BASE_PERIOD),
        .PERIOD_STEP (PERIOD_STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_timer (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_enable   (i_enable),
        .i_restart  (i_restart),
        .i_level    (i_level),
        .o_step_req (step_req)
    );

    for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
        localparam int unsigned SPAWN = spawn_x(k, CAR_INIT_X, GRID_W, NUM_CARS);
        assign spawn_c[k]             = X_W'(SPAWN);
        assign o_car_x[k*X_W +: X_W]  = car_x_q[k];
    end

    // Bitmap is built from next-state positions so it registers together with o_car_x.
    always_comb begin
        occ_d     = '0;
        spawn_occ = '0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (i_restart) begin
                car_x_d[k] = spawn_c[k];
            end else if (step_req) begin
                if (DIRECTION)
                    car_x_d[k] = (car_x_q[k] == X_W'(GRID_W - 1)) ? '0 : car_x_q[k] + X_W'(1);
                else
                    car_x_d[k] = (car_x_q[k] == '0) ? X_W'(GRID_W - 1) : car_x_q[k] - X_W'(1);
            end else begin
                car_x_d[k] = car_x_q[k];
            end
            occ_d[car_x_d[k]]     = 1'b1;
            spawn_occ[spawn_c[k]] = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int k = 0; k < NUM_CARS; k++) car_x_q[k] <= spawn_c[k];
            o_occupied <= spawn_occ;
            o_step     <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CARS; k++) car_x_q[k] <= car_x_d[k];
            o_occupied <= occ_d;
            o_step     <= step_req;
        end
    end

endmodule
